// File: rtl/fault_detection_mc_pkg.sv
// Shared definitions for the multi-channel break / system-failure detector:
// FSM state encoding and fault_src bit ordering.
package fault_detection_mc_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FAULT  = 2'd1,
    HOLD   = 2'd2
  } fault_state_e;

  // Break channels occupy the low fault_src bits, system lines sit directly above.
  localparam int unsigned SRC_BK_BASE = 0;

  function automatic int unsigned src_sys_base(int unsigned num_bk);
    return SRC_BK_BASE + num_bk;
  endfunction

endpackage

// File: rtl/fault_detection_mc_if.sv
// Register/pin/status bundle of fault_detection_mc. The block is the slave side;
// the register file and pad ring form the master side.
interface fault_detection_mc_if #(
  parameter int unsigned NUM_BK  = 4,
  parameter int unsigned NUM_SYS = 2,
  parameter int unsigned FLT_W   = 4
);
  logic [NUM_BK-1:0]          r_bke;
  logic [NUM_BK-1:0]          r_bkp;
  logic [NUM_BK*FLT_W-1:0]    r_bt;
  logic [NUM_SYS-1:0]         r_sys_en;
  logic                       r_latch;
  logic                       r_fault_clr;
  logic [NUM_BK+NUM_SYS-1:0]  r_src_clr;
  logic [NUM_BK-1:0]          advtmr_bk;
  logic [NUM_BK-1:0]          advtmr_bk_oen;
  logic [NUM_SYS-1:0]         system_failure;
  logic                       fault_detected;
  logic [NUM_BK+NUM_SYS-1:0]  fault_src;
  logic [1:0]                 fault_state;
  logic                       int_status_gen_fault_detected;

  modport master (
    output r_bke, r_bkp, r_bt, r_sys_en, r_latch, r_fault_clr, r_src_clr,
           advtmr_bk, system_failure,
    input  advtmr_bk_oen, fault_detected, fault_src, fault_state,
           int_status_gen_fault_detected
  );

  modport slave (
    input  r_bke, r_bkp, r_bt, r_sys_en, r_latch, r_fault_clr, r_src_clr,
           advtmr_bk, system_failure,
    output advtmr_bk_oen, fault_detected, fault_src, fault_state,
           int_status_gen_fault_detected
  );
endinterface

// File: rtl/fault_detection_mc_bk_filter_chan.sv
// One break channel: 2-flop synchroniser, polarity match and saturating
// run-length filter. o_act asserts once the match has held for i_thr cycles.
module fault_detection_mc_bk_filter_chan #(
  parameter int unsigned FLT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pin,
  input  logic             i_en,
  input  logic             i_pol,
  input  logic [FLT_W-1:0] i_thr,
  output logic             o_act
);
  logic             r_sync1;
  logic             r_sync2;
  logic [FLT_W-1:0] r_cnt;
  logic             w_match;

  assign w_match = i_en & (r_sync2 == i_pol);
  assign o_act   = w_match & (r_cnt >= i_thr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (!w_match)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fault_detection_mc.sv
// Multi-channel break detector: filtered break pins plus system-failure lines
// feed a NORMAL/FAULT/HOLD shutdown FSM with sticky per-source status.
module fault_detection_mc
  import fault_detection_mc_pkg::*;
#(
  parameter int unsigned NUM_BK  = 4,
  parameter int unsigned NUM_SYS = 2,
  parameter int unsigned FLT_W   = 4
) (
  input logic                 pe_gen_clk,
  input logic                 pe_gen_rstn,
  fault_detection_mc_if.slave bus
);
  localparam int unsigned SRC_W    = NUM_BK + NUM_SYS;
  localparam int unsigned SYS_BASE = src_sys_base(NUM_BK);

  logic [NUM_BK-1:0]  w_bk_act;
  logic [NUM_SYS-1:0] w_sys_act;
  logic [SRC_W-1:0]   w_src_set;
  logic               w_any_act;

  fault_state_e       r_state;
  logic               r_fault_det;
  logic               r_int;
  logic [SRC_W-1:0]   r_src;

  for (genvar g = 0; g < NUM_BK; g++) begin : g_bk
    fault_detection_mc_bk_filter_chan #(.FLT_W(FLT_W)) u_bk_filter_chan (
      .i_clk   (pe_gen_clk),
      .i_rst_n (pe_gen_rstn),
      .i_pin   (bus.advtmr_bk[g]),
      .i_en    (bus.r_bke[g]),
      .i_pol   (bus.r_bkp[g]),
      .i_thr   (bus.r_bt[g*FLT_W +: FLT_W]),
      .o_act   (w_bk_act[g])
    );
  end

  assign w_sys_act = bus.r_sys_en & bus.system_failure;

  always_comb begin
    w_src_set = '0;
    w_src_set[SRC_BK_BASE +: NUM_BK] = w_bk_act;
    w_src_set[SYS_BASE +: NUM_SYS]   = w_sys_act;
  end

  assign w_any_act = |w_src_set;

  // HOLD leaves only when no source is active; a dropped r_latch acts as a clear.
  always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
    if (!pe_gen_rstn) begin
      r_state     <= NORMAL;
      r_fault_det <= 1'b0;
      r_int       <= 1'b0;
      r_src       <= '0;
    end else begin
      r_int <= 1'b0;
      case (r_state)
        NORMAL: begin
          if (w_any_act) begin
            r_state     <= FAULT;
            r_fault_det <= 1'b1;
            r_int       <= 1'b1;
          end
        end
        FAULT: begin
          if (!w_any_act && bus.r_latch) begin
            r_state     <= HOLD;
            r_fault_det <= 1'b1;
          end else if (!w_any_act) begin
            r_state     <= NORMAL;
            r_fault_det <= 1'b0;
          end
        end
        HOLD: begin
          if (w_any_act) begin
            r_state     <= FAULT;
            r_fault_det <= 1'b1;
          end else if (bus.r_fault_clr || !bus.r_latch) begin
            r_state     <= NORMAL;
            r_fault_det <= 1'b0;
          end
        end
        default: begin
          r_state     <= FAULT;
          r_fault_det <= 1'b1;
        end
      endcase
      r_src <= (r_src & ~bus.r_src_clr) | w_src_set;
    end
  end

  assign bus.advtmr_bk_oen                 = bus.r_bke;
  assign bus.fault_detected                = r_fault_det;
  assign bus.fault_src                     = r_src;
  assign bus.fault_state                   = r_state;
  assign bus.int_status_gen_fault_detected = r_int;
endmodule

// File: tb/tb_fault_detection_mc.sv
// Directed scenarios plus randomized traffic against a behavioural model that
// tracks per-channel match run lengths and the recovery/latch rules.
module tb_fault_detection_mc;
  localparam int unsigned NB = 4;
  localparam int unsigned NS = 2;
  localparam int unsigned FW = 4;
  localparam int unsigned SW = NB + NS;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fault_detection_mc_if #(.NUM_BK(NB), .NUM_SYS(NS), .FLT_W(FW)) bus ();

  fault_detection_mc #(.NUM_BK(NB), .NUM_SYS(NS), .FLT_W(FW)) dut (
    .pe_gen_clk  (clk),
    .pe_gen_rstn (rstn),
    .bus         (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_int  = 0;

  // Behavioural model state
  int            m_state;
  logic          m_fd;
  logic          m_int;
  logic [SW-1:0] m_src;
  logic [SW-1:0] m_act;
  logic [NB-1:0] m_h1;
  logic [NB-1:0] m_s;
  int            m_run [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_fd    = 1'b0;
    m_int   = 1'b0;
    m_src   = '0;
    m_act   = '0;
    m_h1    = '0;
    m_s     = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
  endtask

  // Evaluates the current inputs and advances the model by one clock.
  task automatic model_step();
    logic [SW-1:0] act;
    logic          match;
    logic [FW-1:0] thr;
    logic          any;
    act = '0;
    for (int i = 0; i < NB; i++) begin
      thr      = bus.r_bt[i*FW +: FW];
      match    = bus.r_bke[i] && (m_s[i] == bus.r_bkp[i]);
      act[i]   = match && (m_run[i] >= int'(thr));
      m_run[i] = match ? m_run[i] + 1 : 0;
      m_s[i]   = m_h1[i];
      m_h1[i]  = bus.advtmr_bk[i];
    end
    for (int j = 0; j < NS; j++)
      act[NB+j] = bus.r_sys_en[j] & bus.system_failure[j];
    any   = |act;
    m_act = act;
    m_int = 1'b0;
    if (m_state == 0) begin
      if (any) begin m_state = 1; m_int = 1'b1; end
    end else if (m_state == 1) begin
      if (!any) m_state = bus.r_latch ? 2 : 0;
    end else begin
      if (any) m_state = 1;
      else if (bus.r_fault_clr || !bus.r_latch) m_state = 0;
    end
    m_fd  = (m_state != 0);
    m_src = (m_src & ~bus.r_src_clr) | act;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("fault_detected", 32'(bus.fault_detected), 32'(m_fd));
    chk("fault_state", 32'(bus.fault_state), 32'(m_state));
    chk("fault_src", 32'(bus.fault_src), 32'(m_src));
    chk("int_pulse", 32'(bus.int_status_gen_fault_detected), 32'(m_int));
    chk("bk_oen", 32'(bus.advtmr_bk_oen), 32'(bus.r_bke));
    if (bus.int_status_gen_fault_detected) n_int++;
  endtask

  task automatic zero_inputs();
    bus.r_bke          = '0;
    bus.r_bkp          = '0;
    bus.r_bt           = '0;
    bus.r_sys_en       = '0;
    bus.r_latch        = 1'b0;
    bus.r_fault_clr    = 1'b0;
    bus.r_src_clr      = '0;
    bus.advtmr_bk      = '0;
    bus.system_failure = '0;
  endtask

  task automatic clear_src();
    bus.r_src_clr = '1;
    tick();
    bus.r_src_clr = '0;
  endtask

  initial begin
    int ch;
    rstn = 1'b0;
    zero_inputs();
    model_reset();
    #2;
    chk("rst_fd", 32'(bus.fault_detected), 32'd0);
    chk("rst_state", 32'(bus.fault_state), 32'd0);
    chk("rst_src", 32'(bus.fault_src), 32'd0);
    chk("rst_int", 32'(bus.int_status_gen_fault_detected), 32'd0);
    #10 rstn = 1'b1;

    // Filtering: threshold 3, pin high 5 clocks
    bus.r_bke = 4'b0001; bus.r_bkp = 4'b0001; bus.r_bt = 16'h0003;
    n_int = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.advtmr_bk = (k <= 5) ? 4'b0001 : 4'b0000;
      tick();
      if (k == 5) chk("filt_pre", 32'(bus.fault_detected), 32'd0);
      if (k == 6) chk("filt_rise", 32'(bus.fault_detected), 32'd1);
    end
    chk("filt_int", 32'(n_int), 32'd1);
    chk("filt_src", 32'(bus.fault_src), 32'b000001);
    clear_src();

    // Glitch rejection: pulse of 3 clocks with threshold 3
    n_int = 0;
    for (int k = 1; k <= 10; k++) begin
      bus.advtmr_bk = (k <= 3) ? 4'b0001 : 4'b0000;
      tick();
      chk("glitch_fd", 32'(bus.fault_detected), 32'd0);
      chk("glitch_src", 32'(bus.fault_src), 32'd0);
    end
    chk("glitch_int", 32'(n_int), 32'd0);

    // Auto recovery from system_failure[1]
    bus.r_bke = '0; bus.r_sys_en = 2'b10; bus.r_latch = 1'b0;
    n_int = 0;
    for (int k = 1; k <= 8; k++) begin
      bus.system_failure = (k <= 4) ? 2'b10 : 2'b00;
      tick();
      chk("auto_fd", 32'(bus.fault_detected), (k <= 4) ? 32'd1 : 32'd0);
    end
    chk("auto_state", 32'(bus.fault_state), 32'd0);
    chk("auto_src5", 32'(bus.fault_src[5]), 32'd1);
    chk("auto_int", 32'(n_int), 32'd1);
    bus.r_src_clr = 6'b100000;
    tick();
    bus.r_src_clr = '0;
    chk("auto_src5_clr", 32'(bus.fault_src[5]), 32'd0);

    // Latched mode
    bus.r_latch = 1'b1; bus.r_sys_en = 2'b01;
    bus.r_bke = 4'b0001; bus.r_bkp = 4'b0001; bus.r_bt = '0;
    n_int = 0;
    bus.advtmr_bk = 4'b0001;
    repeat (3) tick();
    chk("latch_fault", 32'(bus.fault_state), 32'd1);
    bus.advtmr_bk = 4'b0000;
    repeat (5) tick();
    chk("latch_hold", 32'(bus.fault_state), 32'd2);
    chk("latch_hold_fd", 32'(bus.fault_detected), 32'd1);
    bus.system_failure = 2'b01; bus.r_fault_clr = 1'b1;
    tick();
    bus.r_fault_clr = 1'b0;
    chk("latch_reassert", 32'(bus.fault_state), 32'd1);
    chk("latch_no_int", 32'(n_int), 32'd1);
    bus.system_failure = 2'b00;
    tick();
    chk("latch_hold2", 32'(bus.fault_state), 32'd2);
    bus.r_fault_clr = 1'b1;
    tick();
    bus.r_fault_clr = 1'b0;
    chk("latch_clr_state", 32'(bus.fault_state), 32'd0);
    chk("latch_clr_fd", 32'(bus.fault_detected), 32'd0);
    bus.system_failure = 2'b01; tick();
    bus.system_failure = 2'b00; tick();
    chk("latch_hold3", 32'(bus.fault_state), 32'd2);
    bus.r_latch = 1'b0;
    tick();
    chk("unlatch_state", 32'(bus.fault_state), 32'd0);
    clear_src();

    // Set wins over W1C clear; active-low polarity
    bus.advtmr_bk = 4'b0001;
    tick(); tick();
    bus.r_src_clr = 6'b000001;
    tick();
    bus.r_src_clr = '0;
    chk("simul_src0", 32'(bus.fault_src[0]), 32'd1);
    bus.advtmr_bk = 4'b0000;
    repeat (6) tick();
    clear_src();
    bus.r_bke = 4'b0010; bus.r_bkp = 4'b0000;
    tick();
    chk("pol_low_fd", 32'(bus.fault_detected), 32'd1);
    chk("pol_low_src", 32'(bus.fault_src), 32'b000010);
    bus.r_bke = 4'b0000;
    repeat (3) tick();
    chk("disable_state", 32'(bus.fault_state), 32'd0);

    // Asynchronous reset while in HOLD
    bus.r_latch = 1'b1;
    bus.system_failure = 2'b01; tick();
    bus.system_failure = 2'b00; tick();
    chk("pre_rst_hold", 32'(bus.fault_state), 32'd2);
    #2 rstn = 1'b0;
    #1;
    chk("arst_fd", 32'(bus.fault_detected), 32'd0);
    chk("arst_state", 32'(bus.fault_state), 32'd0);
    chk("arst_src", 32'(bus.fault_src), 32'd0);
    chk("arst_int", 32'(bus.int_status_gen_fault_detected), 32'd0);
    zero_inputs();
    model_reset();
    #3 rstn = 1'b1;

    // Randomized traffic
    bus.r_bke = 4'b1111; bus.r_bkp = 4'($urandom); bus.r_bt = 16'h1203;
    bus.r_sys_en = 2'b11;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(5) == 0) begin
        ch = int'($urandom_range(NB - 1));
        bus.advtmr_bk[ch] = ~bus.advtmr_bk[ch];
      end
      if ($urandom_range(63) == 0) bus.r_bke = 4'($urandom);
      if ($urandom_range(63) == 0) bus.r_bkp = 4'($urandom);
      if ($urandom_range(63) == 0) bus.r_bt = 16'($urandom) & 16'h3333;
      if ($urandom_range(255) == 0) bus.r_bt = 16'($urandom);
      if ($urandom_range(31) == 0) bus.r_sys_en = 2'($urandom);
      if ($urandom_range(11) == 0) bus.system_failure = bus.system_failure ^ 2'($urandom_range(1, 3));
      if ($urandom_range(31) == 0) bus.r_latch = ~bus.r_latch;
      bus.r_fault_clr = ($urandom_range(7) == 0);
      bus.r_src_clr = ($urandom_range(7) == 0) ? 6'($urandom) : 6'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fault_detection_mc.md
Name: fault_detection_mc

Overview:
- Multi-channel successor to the single-pair advanced-timer break detector, inside advtim_pe_core.
- Monitors NUM_BK external break pins and NUM_SYS internal system-failure lines.
- Each break pin has its own enable, polarity, 2-flop synchroniser and saturating digital filter.
- A 3-state FSM drives fault_detected (PWM shutdown) in auto-recovery or latched mode, with per-source sticky W1C status and a one-cycle interrupt pulse.

Parameters:
- NUM_BK, 4, number of external break channels (1..8).
- NUM_SYS, 2, number of internal system-failure inputs (1..8).
- FLT_W, 4, width of each channel's filter threshold and counter.

Ports:
- pe_gen_clk  in  1  block clock.
- pe_gen_rstn  in  1  asynchronous active-low reset.
- r_bke  in  NUM_BK  per-channel break enable.
- r_bkp  in  NUM_BK  per-channel active polarity (1 = active high).
- r_bt  in  NUM_BK*FLT_W  per-channel filter threshold; channel i uses slice [i*FLT_W +: FLT_W].
- r_sys_en  in  NUM_SYS  per-line system-failure enable.
- r_latch  in  1  0 = auto-recovery, 1 = latched until software clear.
- r_fault_clr  in  1  one-cycle software clear request.
- r_src_clr  in  NUM_BK+NUM_SYS  W1C pulses that clear fault_src bits.
- advtmr_bk  in  NUM_BK  asynchronous break pins.
- advtmr_bk_oen  out  NUM_BK  pin direction; equals r_bke bitwise (1 = input).
- system_failure  in  NUM_SYS  synchronous internal failure lines.
- fault_detected  out  1  registered PWM shutdown request.
- fault_src  out  NUM_BK+NUM_SYS  sticky source flags; breaks in the low bits, system lines above.
- fault_state  out  2  FSM state encoding.
- int_status_gen_fault_detected  out  1  one-cycle pulse on fault entry.

Behaviour:
- Reset values: fault_detected=0, fault_src=0, fault_state=NORMAL, int pulse=0, synchronisers=0, counters=0.
- Synchroniser and match:
  - Each pin passes through a 2-flop synchroniser to give s[i].
  - match[i] = r_bke[i] & (s[i] == r_bkp[i]).
- Filter:
  - cnt[i] increments while match[i] is high and saturates at all-ones.
  - cnt[i] clears to 0 on any cycle where match[i] is low, including when r_bke[i]=0.
  - bk_act[i] = match[i] & (cnt[i] >= r_bt[i]).
  - r_bt[i]=0 gives no filtering.
- System sources: sys_act[j] = r_sys_en[j] & system_failure[j]. No synchroniser, no filter.
- any_act = OR of all bk_act and sys_act.
- Latency:
  - Pin edge to fault_detected rising = 3 + r_bt[i] clocks, with the pin held stable throughout.
  - system_failure to fault_detected = 1 clock.
- FSM (encodings NORMAL=0, FAULT=1, HOLD=2; 3 is illegal and recovers to FAULT):
  - NORMAL: any_act goes to FAULT and pulses int_status for 1 cycle.
  - FAULT: !any_act & !r_latch goes to NORMAL. !any_act & r_latch goes to HOLD. Otherwise stay.
  - HOLD: any_act goes to FAULT with no new int pulse. Otherwise r_fault_clr goes to NORMAL. Otherwise stay.
  - fault_detected = 1 in FAULT and HOLD, registered together with the state.
- r_fault_clr:
  - Ignored in NORMAL and FAULT.
  - Honoured in HOLD only when any_act=0 in the same cycle.
  - Clearing an active fault is impossible.
- r_latch toggled 1->0 while in HOLD: next cycle goes to NORMAL.
- fault_src:
  - A bit sets on any cycle its source is active.
  - r_src_clr clears the bit.
  - Set wins when set and clear hit the same bit in the same cycle.
  - fault_src is independent of the FSM clear.
- Disabling a channel mid-fault removes it from any_act next cycle; the FSM then follows the rules above.
- Async reset mid-fault: all outputs return to reset values immediately.

Decomposition:
- Shared package holds FSM state localparams (NORMAL/FAULT/HOLD) and the fault_src bit-ordering constants.
- Natural sub-module: bk_filter_chan, instantiated NUM_BK times via generate. It contains the synchroniser, polarity match and saturating counter, and outputs bk_act.
- Top level holds the OR-reduce, FSM, sticky status and interrupt.

Test Plan:
- Filtering: NUM_BK=4, r_bke=4'b0001, r_bkp[0]=1, r_bt[0]=3. Pin 0 high for 5 clks gives fault_detected high at clk 6 and 1 int pulse; fault_src=6'b000001.
- Glitch rejection: r_bt[0]=3, pin pulsed high for 3 clks gives fault_detected=0 and fault_src=0 throughout.
- Auto recovery: r_latch=0, system_failure[1] high 4 clks with r_sys_en=2'b10. fault_detected is high for 4 clks starting 1 clk late, then state returns to NORMAL; fault_src[5]=1 until r_src_clr[5] is pulsed.
- Latched mode: r_latch=1, break clears and state enters HOLD.
  - r_fault_clr while the source is re-asserted gives FAULT with no int pulse.
  - Source removed then r_fault_clr gives NORMAL the next clk.
- Simultaneous events: r_src_clr[0] in the same clk as bk_act[0] leaves fault_src[0]=1. Polarity r_bkp=0 with the pin low triggers the fault.
- Reset mid-fault: assert pe_gen_rstn=0 in HOLD. All outputs go to 0 asynchronously and fault_state=0.
